fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch controller: program counter with multi-program start sequencing, conditional relative/absolute branches, a hardware call/return stack and a run/halt state machine. It drives the instruction ROM address and replaces the single-width, stackless program counter in the processor datapath. Decode supplies the control strobes; the ROM sits combinationally on `ProgCtr`.

## Interface
- `PC_W`, 10: program counter / `Target` width.
- `NUM_PROGS`, 3: number of entries in the program start table (`fetch_pkg::PROG_START`).
- `STACK_DEPTH`, 4: return-stack entries (power of two, ≥2).

Ports:
- `Clk`  in  1  single clock, all state updates on posedge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `Start`  in  1  load the next program's start address and run.
- `Halt`  in  1  stop fetching (program end).
- `BranchRel`  in  1  relative branch, taken when `ALU_flag`=1.
- `BranchAbs`  in  1  absolute branch, taken when `ALU_flag`=1.
- `Call`  in  1  unconditional call to `Target`, pushes return address.
- `Ret`  in  1  pop return address into PC.
- `ALU_flag`  in  1  branch condition.
- `Target`  in  PC_W  absolute address, or signed two's-complement offset for `BranchRel`.
- `ProgCtr`  out  PC_W  current fetch address (ROM address).
- `ProgIdx`  out  $clog2(NUM_PROGS)  index of the program most recently started.
- `Running`  out  1  state == RUN.
- `Done`  out  1  state == HALT.
- `StackErr`  out  1  sticky: return-stack overflow or underflow occurred.

## Operation
- States: IDLE (after reset), RUN, HALT.
- Reset: `ProgCtr`=0, `ProgIdx`=0, next-program pointer=0, stack empty, IDLE, `Running`=0, `Done`=0, `StackErr`=0.
- Start (any state, highest priority): `ProgCtr` ← `PROG_START[ptr]`, `ProgIdx` ← ptr, ptr ← ptr+1 wrapping to 0 after `NUM_PROGS`-1, stack cleared, `StackErr` cleared, → RUN. Start held high for N cycles loads N successive programs.
- IDLE/HALT without Start: all state holds; every other input ignored.
- RUN, priority Halt > Ret > Call > BranchAbs > BranchRel > increment (one action per cycle):
  - Halt: → HALT, `ProgCtr` holds.
  - Ret: stack non-empty → `ProgCtr` ← pop; empty → `StackErr`=1, → HALT, PC holds.
  - Call: stack not full → push `ProgCtr`+1, `ProgCtr` ← `Target`; full → `StackErr`=1, → HALT, no push, PC holds.
  - BranchAbs & `ALU_flag`: `ProgCtr` ← `Target`.
  - BranchRel & `ALU_flag`: `ProgCtr` ← `ProgCtr` + signed(`Target`), modulo 2^PC_W.
  - Branch with `ALU_flag`=0, or no control: `ProgCtr` ← `ProgCtr`+1, wrapping from 2^PC_W−1 to 0.
- Return address `ProgCtr`+1 also wraps modulo 2^PC_W.

## Timing
- All outputs registered; state changes visible one cycle after the sampling edge. `ProgCtr` is valid for ROM read for the whole cycle.
- Branch/call/return: zero bubble; new address on the cycle after the strobe.
- Push and pop never coincide (priority), so stack has single-op per cycle.
- Reset asserted mid-operation: outputs reach reset values immediately (asynchronously), independent of `Clk`.
- Start and Halt in same cycle: Start wins (→ RUN).

## Structure
- `fetch_pkg`: `state_t` enum {IDLE, RUN, HALT}; `PROG_START` constant array (default entries 0, 128, 256); `PC_W` default.
- Sub-module `return_stack`: parametrised LIFO (`WIDTH`, `DEPTH`), push/pop/clear, `full`/`empty` flags, asynchronous reset; top level owns error and priority logic.

## Test plan
- Reset, then 2 cycles with no Start → `ProgCtr`=0, `Running`=0; Start one cycle → `ProgCtr`=0, `ProgIdx`=0, `Running`=1.
- Start pulses separated by idle/RUN cycles → `ProgCtr` 128 (`ProgIdx`=1), then 256 (`ProgIdx`=2), then 0 (wrap, `ProgIdx`=0).
- At PC=130: BranchRel, Target=10'h3FC (−4), `ALU_flag`=1 → 126; same with `ALU_flag`=0 → 131; BranchAbs Target=5 flag=1 → 5; PC=1023 increment → 0.
- Call Target=40 at PC=10 → 40; nested Call at 40 → Target 60; Ret → 41; Ret → 11; extra Ret → `StackErr`=1, `Done`=1, PC=11 held.
- Five Calls with `STACK_DEPTH`=4 → fifth sets `StackErr`, HALT, PC unchanged; Start → `StackErr`=0, RUN at next program.
- Reset asserted between clock edges while RUN at PC=77 with stack depth 2 → `ProgCtr`=0, IDLE, stack empty before next posedge; Halt+Start same cycle → RUN.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The program start table lives here so decode and fetch agree on entry points.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned PC_W_DEFAULT        = 10;
  localparam int unsigned NUM_PROGS_DEFAULT   = 3;
  localparam int unsigned STACK_DEPTH_DEFAULT = 4;

  localparam logic [31:0] PROG_START [NUM_PROGS_DEFAULT] = '{32'd0, 32'd128, 32'd256};

  // Out-of-table indices map to address 0 so oversized NUM_PROGS stays defined.
  function automatic logic [31:0] prog_start_addr(input int unsigned idx);
    logic [31:0] addr;
    addr = '0;
    for (int unsigned i = 0; i < NUM_PROGS_DEFAULT; i++) begin
      if (i == idx) addr = PROG_START[i];
    end
    return addr;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control/status bundle between decode (master) and the fetch unit (slave).
// Decode drives the strobes and branch target; fetch returns the ROM address and status.
interface fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  parameter int unsigned IDX_W = idx_width(NUM_PROGS_DEFAULT)
) ();

  logic             Start;
  logic             Halt;
  logic             BranchRel;
  logic             BranchAbs;
  logic             Call;
  logic             Ret;
  logic             ALU_flag;
  logic [PC_W-1:0]  Target;

  logic [PC_W-1:0]  ProgCtr;
  logic [IDX_W-1:0] ProgIdx;
  logic             Running;
  logic             Done;
  logic             StackErr;

  modport master (
    output Start, Halt, BranchRel, BranchAbs, Call, Ret, ALU_flag, Target,
    input  ProgCtr, ProgIdx, Running, Done, StackErr
  );

  modport slave (
    input  Start, Halt, BranchRel, BranchAbs, Call, Ret, ALU_flag, Target,
    output ProgCtr, ProgIdx, Running, Done, StackErr
  );

endinterface

// File: rtl/return_stack.sv
// Small LIFO for call return addresses. Overflowing pushes and underflowing
// pops are dropped here; the caller decides what an error means.
module return_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign wr_idx  = cnt_q[PTR_W-1:0];
  assign top_idx = cnt_q[PTR_W-1:0] - 1'b1;
  assign rdata   = mem_q[top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (do_push) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Contents need no reset: the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch controller: program counter, start-table sequencing,
// conditional branches, call/return stack and run/halt sequencing.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEFAULT,
  parameter int unsigned NUM_PROGS   = NUM_PROGS_DEFAULT,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEFAULT,
  localparam int unsigned IDX_W      = idx_width(NUM_PROGS)
) (
  input logic         Clk,
  input logic         Reset,
  fetch_unit_if.slave bus
);

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic             stk_push;
  logic             stk_pop;
  logic             stk_clear;
  logic             stk_full;
  logic             stk_empty;
  logic [PC_W-1:0]  stk_rdata;
  logic [PC_W-1:0]  ret_addr;
  logic [PC_W-1:0]  start_pc;
  logic             branch_taken;

  assign ret_addr     = pc_q + 1'b1;
  assign start_pc     = PC_W'(prog_start_addr(32'(ptr_q)));
  assign branch_taken = bus.ALU_flag;

  return_stack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk   (Clk),
    .rst   (Reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .clear (stk_clear),
    .wdata (ret_addr),
    .rdata (stk_rdata),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;

    if (bus.Start) begin
      // Start overrides everything, including Halt in the same cycle.
      pc_d      = start_pc;
      idx_d     = ptr_q;
      ptr_d     = (ptr_q == IDX_W'(NUM_PROGS - 1)) ? '0 : ptr_q + 1'b1;
      stk_clear = 1'b1;
      err_d     = 1'b0;
      state_d   = RUN;
    end else if (state_q == RUN) begin
      if (bus.Halt) begin
        state_d = HALT;
      end else if (bus.Ret) begin
        if (!stk_empty) begin
          stk_pop = 1'b1;
          pc_d    = stk_rdata;
        end else begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end else if (bus.Call) begin
        if (!stk_full) begin
          stk_push = 1'b1;
          pc_d     = bus.Target;
        end else begin
          err_d   = 1'b1;
          state_d = HALT;
        end
      end else if (bus.BranchAbs && branch_taken) begin
        pc_d = bus.Target;
      end else if (bus.BranchRel && branch_taken) begin
        // Two's-complement add wraps modulo 2^PC_W, giving signed offsets for free.
        pc_d = pc_q + bus.Target;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign bus.ProgCtr  = pc_q;
  assign bus.ProgIdx  = idx_q;
  assign bus.Running  = (state_q == RUN);
  assign bus.Done     = (state_q == HALT);
  assign bus.StackErr = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start sequencing, branches, call/return,
// stack errors, priority and asynchronous reset, with hand-computed expectations.
module tb_fetch_unit;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  fetch_unit_if #(.PC_W(10), .IDX_W(2)) bus ();

  fetch_unit #(
    .PC_W        (10),
    .NUM_PROGS   (3),
    .STACK_DEPTH (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pc(input string tag, input int unsigned exp);
    check({tag, ".pc"}, 32'(bus.ProgCtr), exp);
  endtask

  task automatic chk_st(input string tag, input int unsigned run, input int unsigned done,
                        input int unsigned err);
    check({tag, ".run"}, 32'(bus.Running), run);
    check({tag, ".done"}, 32'(bus.Done), done);
    check({tag, ".err"}, 32'(bus.StackErr), err);
  endtask

  task automatic chk_idx(input string tag, input int unsigned exp);
    check({tag, ".idx"}, 32'(bus.ProgIdx), exp);
  endtask

  task automatic idle_inputs();
    bus.Start     = 1'b0;
    bus.Halt      = 1'b0;
    bus.BranchRel = 1'b0;
    bus.BranchAbs = 1'b0;
    bus.Call      = 1'b0;
    bus.Ret       = 1'b0;
    bus.ALU_flag  = 1'b0;
    bus.Target    = '0;
  endtask

  // Inputs are set just after an edge and cleared after the next one.
  task automatic tick();
    @(posedge Clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    #11;
    chk_pc("reset", 0); chk_idx("reset", 0); chk_st("reset", 0, 0, 0);
    #1 Reset = 1'b0;

    tick(); tick();
    chk_pc("idle", 0); chk_st("idle", 0, 0, 0);

    bus.Start = 1'b1; tick();
    chk_pc("start0", 0); chk_idx("start0", 0); chk_st("start0", 1, 0, 0);
    tick(); tick();
    chk_pc("inc", 2);

    bus.Start = 1'b1; tick();
    chk_pc("start1", 128); chk_idx("start1", 1);
    bus.Halt = 1'b1; tick();
    chk_pc("halt", 128); chk_st("halt", 0, 1, 0);
    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd5; bus.Call = 1'b1; tick();
    chk_pc("halt_ignore", 128); chk_st("halt_ignore", 0, 1, 0);

    // Start held two cycles loads two successive programs.
    bus.Start = 1'b1; tick();
    chk_pc("start2", 256); chk_idx("start2", 2); chk_st("start2", 1, 0, 0);
    bus.Start = 1'b1; tick();
    chk_pc("start_wrap", 0); chk_idx("start_wrap", 0);

    bus.Start = 1'b1; tick();
    tick(); tick();
    chk_pc("at130", 130); chk_idx("at130", 1);

    bus.BranchRel = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'h3FC; tick();
    chk_pc("brel_neg", 126);
    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd130; tick();
    chk_pc("babs130", 130);
    bus.BranchRel = 1'b1; bus.ALU_flag = 1'b0; bus.Target = 10'h3FC; tick();
    chk_pc("brel_nt", 131);
    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd5; tick();
    chk_pc("babs5", 5);
    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b0; bus.Target = 10'd99; tick();
    chk_pc("babs_nt", 6);
    bus.BranchRel = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd10; tick();
    chk_pc("brel_pos", 16);
    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd1023; tick();
    chk_pc("babs1023", 1023);
    tick();
    chk_pc("pc_wrap", 0);

    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd10; tick();
    bus.Call = 1'b1; bus.Target = 10'd40; tick();
    chk_pc("call40", 40);
    bus.Call = 1'b1; bus.Target = 10'd60; tick();
    chk_pc("call60", 60);
    bus.Ret = 1'b1; tick();
    chk_pc("ret41", 41);
    bus.Ret = 1'b1; tick();
    chk_pc("ret11", 11); chk_st("ret11", 1, 0, 0);
    bus.Ret = 1'b1; tick();
    chk_pc("underflow", 11); chk_st("underflow", 0, 1, 1);

    bus.Start = 1'b1; tick();
    chk_pc("restart", 256); chk_idx("restart", 2); chk_st("restart", 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.Call = 1'b1; bus.Target = 10'(300 + i); tick();
      chk_pc($sformatf("call_fill%0d", i), 300 + i);
    end
    bus.Call = 1'b1; bus.Target = 10'd304; tick();
    chk_pc("overflow", 303); chk_st("overflow", 0, 1, 1);
    bus.Start = 1'b1; tick();
    chk_pc("after_ovf", 0); chk_idx("after_ovf", 0); chk_st("after_ovf", 1, 0, 0);

    bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd1023; tick();
    bus.Call = 1'b1; bus.Target = 10'd7; tick();
    chk_pc("call_wrap", 7);
    bus.Ret = 1'b1; tick();
    chk_pc("ret_wrap", 0);

    // Start must empty the stack: the Ret that follows underflows.
    bus.Call = 1'b1; bus.Target = 10'd50; tick();
    bus.Start = 1'b1; tick();
    chk_pc("start_clr", 128); chk_idx("start_clr", 1);
    bus.Ret = 1'b1; tick();
    chk_pc("clr_ret", 128); chk_st("clr_ret", 0, 1, 1);

    bus.Start = 1'b1; tick();
    bus.Call = 1'b1; bus.BranchAbs = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 10'd20; tick();
    chk_pc("call_over_babs", 20);
    bus.Ret = 1'b1; bus.Call = 1'b1; bus.Target = 10'd99; tick();
    chk_pc("ret_over_call", 257);
    bus.Halt = 1'b1; bus.Ret = 1'b1; tick();
    chk_pc("halt_over_ret", 257); chk_st("halt_over_ret", 0, 1, 0);

    bus.Start = 1'b1; tick();
    chk_idx("pre_rst", 0);
    bus.Call = 1'b1; bus.Target = 10'd30; tick();
    bus.Call = 1'b1; bus.Target = 10'd76; tick();
    tick();
    chk_pc("at77", 77);
    #2 Reset = 1'b1;
    #1;
    chk_pc("async_rst", 0); chk_idx("async_rst", 0); chk_st("async_rst", 0, 0, 0);
    #2 Reset = 1'b0;
    tick();

    bus.Start = 1'b1; tick();
    chk_pc("post_rst", 0); chk_idx("post_rst", 0);
    bus.Ret = 1'b1; tick();
    chk_st("post_rst_empty", 0, 1, 1);

    bus.Start = 1'b1; bus.Halt = 1'b1; tick();
    chk_pc("start_halt", 128); chk_idx("start_halt", 1); chk_st("start_halt", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
